// File: rtl/xbus_responder.sv
// Register-bus responder: synchronizes the async cs_n/rd_nwr strobes and turns
// even/odd byte accesses into 16-bit register writes and buffered register reads.
module xbus_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_cs_n_i,
    input  logic        bus_rd_nwr_i,
    input  logic [3:0]  bus_reg_num_i,
    input  logic        bus_bytesel_i,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    output logic        reg_wr_o,
    output logic [3:0]  reg_wr_num_o,
    output logic [15:0] reg_wr_data_o,
    output logic        reg_rd_o,
    output logic [3:0]  reg_rd_num_o,
    input  logic [15:0] reg_rd_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_CAP,
        DRIVE,
        WAIT_REL
    } state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_rw_sync, r_sync_live;
    logic        r_cs_prev, r_armed;
    logic [3:0]  r_rnum, r_buf_num;
    logic        r_bsel, r_buf_vld;
    logic [7:0]  r_wbyte, r_hi_latch;
    logic [15:0] r_rd_buf;

    logic w_cs_s, w_rw_s, w_live, w_start, w_fetch;

    assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
    assign w_rw_s  = r_rw_sync[SYNC_STAGES-1];
    // r_sync_live marks when the synchronizer output reflects the pin rather than
    // its reset value, so a cs_n held low through reset never arms the detector.
    assign w_live  = r_sync_live[SYNC_STAGES-1];
    assign w_start = r_armed & r_cs_prev & ~w_cs_s;
    assign w_fetch = ~bus_bytesel_i | (bus_reg_num_i != r_buf_num) | ~r_buf_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cs_sync   <= '1;
            r_rw_sync   <= '1;
            r_sync_live <= '0;
            r_cs_prev   <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus_cs_n_i};
            r_rw_sync   <= {r_rw_sync[SYNC_STAGES-2:0], bus_rd_nwr_i};
            r_sync_live <= {r_sync_live[SYNC_STAGES-2:0], 1'b1};
            r_cs_prev   <= w_cs_s;
            r_armed     <= r_armed | (w_cs_s & w_live);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rnum     <= '0;
            r_bsel     <= 1'b0;
            r_wbyte    <= '0;
            r_hi_latch <= '0;
            r_rd_buf   <= '0;
            r_buf_num  <= '0;
            r_buf_vld  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_start) begin
                r_rnum  <= bus_reg_num_i;
                r_bsel  <= bus_bytesel_i;
                r_wbyte <= bus_data_i;
            end
            if (r_state == WR && !r_bsel)
                r_hi_latch <= r_wbyte;
            // A write to the buffered register makes the buffer stale.
            if (r_state == WR && r_bsel && r_rnum == r_buf_num)
                r_buf_vld <= 1'b0;
            if (r_state == RD_CAP) begin
                r_rd_buf  <= reg_rd_data_i;
                r_buf_num <= r_rnum;
                r_buf_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        bus_data_o    = '0;
        bus_data_oe_o = 1'b0;
        reg_wr_o      = 1'b0;
        reg_wr_num_o  = '0;
        reg_wr_data_o = '0;
        reg_rd_o      = 1'b0;
        reg_rd_num_o  = '0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (!w_rw_s)      w_next = WR;
                    else if (w_fetch) w_next = RD_REQ;
                    else              w_next = DRIVE;
                end
            end
            WR: begin
                if (r_bsel) begin
                    reg_wr_o      = 1'b1;
                    reg_wr_num_o  = r_rnum;
                    reg_wr_data_o = {r_hi_latch, r_wbyte};
                end
                w_next = WAIT_REL;
            end
            RD_REQ: begin
                reg_rd_o     = 1'b1;
                reg_rd_num_o = r_rnum;
                w_next       = RD_CAP;
            end
            RD_CAP: w_next = DRIVE;
            DRIVE: begin
                bus_data_oe_o = 1'b1;
                bus_data_o    = r_bsel ? r_rd_buf[7:0] : r_rd_buf[15:8];
                if (w_cs_s) w_next = IDLE;
            end
            WAIT_REL: begin
                if (w_cs_s) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbus_responder.sv
// Scoreboard bench for xbus_responder: a protocol model queues expected strobes
// and read bytes; the access task pops and compares them as the DUT produces them.
module tb_xbus_responder;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bus_cs_n_i;
    logic        bus_rd_nwr_i;
    logic [3:0]  bus_reg_num_i;
    logic        bus_bytesel_i;
    logic [7:0]  bus_data_i;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe_o;
    logic        reg_wr_o;
    logic [3:0]  reg_wr_num_o;
    logic [15:0] reg_wr_data_o;
    logic        reg_rd_o;
    logic [3:0]  reg_rd_num_o;
    logic [15:0] reg_rd_data_i;

    xbus_responder #(.SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus_cs_n_i    (bus_cs_n_i),
        .bus_rd_nwr_i  (bus_rd_nwr_i),
        .bus_reg_num_i (bus_reg_num_i),
        .bus_bytesel_i (bus_bytesel_i),
        .bus_data_i    (bus_data_i),
        .bus_data_o    (bus_data_o),
        .bus_data_oe_o (bus_data_oe_o),
        .reg_wr_o      (reg_wr_o),
        .reg_wr_num_o  (reg_wr_num_o),
        .reg_wr_data_o (reg_wr_data_o),
        .reg_rd_o      (reg_rd_o),
        .reg_rd_num_o  (reg_rd_num_o),
        .reg_rd_data_i (reg_rd_data_i)
    );

    always #5 clk = ~clk;

    // Downstream register file: written by DUT strobes, read data one cycle later.
    logic [15:0] regfile [16];
    always @(posedge clk) begin
        if (reg_wr_o) regfile[reg_wr_num_o] <= reg_wr_data_o;
        if (reg_rd_o) reg_rd_data_i <= regfile[reg_rd_num_o];
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] q_wr[$];
    logic [3:0]  q_rd[$];
    logic [7:0]  q_byte[$];

    logic [15:0] m_mem [16];
    logic [7:0]  m_hi;
    logic [15:0] m_buf;
    logic [3:0]  m_bufnum;
    bit          m_vld;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = '0;
        m_buf = '0;
        m_bufnum = '0;
        m_vld = 1'b0;
    endtask

    task automatic access(input bit rd, input logic [3:0] num, input bit bsel,
                          input logic [7:0] d, input int low);
        int wr_k = 0, rd_k = 0, oe_k = 0, wr_n = 0, rd_n = 0, oe_n = 0;
        int ewr_k = 0, erd_k = 0, eoe_k = 0, eoe_n = 0;
        bit fetch;
        logic [19:0] ewr;
        if (!rd) begin
            if (!bsel) m_hi = d;
            else begin
                q_wr.push_back({num, m_hi, d});
                m_mem[num] = {m_hi, d};
                if (num == m_bufnum) m_vld = 1'b0;
                ewr_k = SS + 1;
            end
        end else begin
            fetch = !bsel || num != m_bufnum || !m_vld;
            if (fetch) begin
                q_rd.push_back(num);
                m_buf = m_mem[num];
                m_bufnum = num;
                m_vld = 1'b1;
                erd_k = SS + 1;
                eoe_k = SS + 3;
            end else begin
                eoe_k = SS + 1;
            end
            q_byte.push_back(bsel ? m_buf[7:0] : m_buf[15:8]);
            eoe_n = low + SS - eoe_k + 1;
            if (eoe_n < 1) eoe_n = 1;
        end
        @(negedge clk);
        bus_rd_nwr_i = rd; bus_reg_num_i = num; bus_bytesel_i = bsel; bus_data_i = d;
        @(negedge clk);
        bus_cs_n_i = 1'b0;
        for (int k = 1; k <= low + SS + 6; k++) begin
            @(posedge clk);
            #1;
            if (reg_wr_o) begin
                wr_n++;
                if (wr_k == 0) wr_k = k;
                if (q_wr.size() == 0) check_val("wr_unexpected", 1, 0);
                else begin
                    ewr = q_wr.pop_front();
                    check_val("wr_num_data", {reg_wr_num_o, reg_wr_data_o}, ewr);
                end
            end
            if (reg_rd_o) begin
                rd_n++;
                if (rd_k == 0) rd_k = k;
                if (q_rd.size() == 0) check_val("rd_unexpected", 1, 0);
                else check_val("rd_num", reg_rd_num_o, q_rd.pop_front());
            end
            if (bus_data_oe_o) begin
                oe_n++;
                if (oe_k == 0) begin
                    oe_k = k;
                    if (q_byte.size() == 0) check_val("oe_unexpected", 1, 0);
                    else check_val("rd_byte", bus_data_o, q_byte.pop_front());
                end
            end
            if (k == low) bus_cs_n_i = 1'b1;
        end
        check_val("wr_cycle", wr_k, ewr_k);
        check_val("wr_count", wr_n, (ewr_k != 0) ? 1 : 0);
        check_val("rd_cycle", rd_k, erd_k);
        check_val("rd_count", rd_n, (erd_k != 0) ? 1 : 0);
        check_val("oe_cycle", oe_k, eoe_k);
        check_val("oe_count", oe_n, eoe_n);
    endtask

    initial begin
        int strobes;
        reset_n = 1'b0;
        bus_cs_n_i = 1'b1; bus_rd_nwr_i = 1'b1; bus_reg_num_i = '0;
        bus_bytesel_i = 1'b0; bus_data_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  {bus_data_o, bus_data_oe_o, reg_wr_o, reg_wr_num_o, reg_wr_data_o, reg_rd_o, reg_rd_num_o},
                  '0);
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Byte-pair writes; odd byte carries the 16-bit write
        access(0, 4'd3, 0, 8'h12, SS + 5);
        access(0, 4'd3, 1, 8'h34, SS + 5);
        access(0, 4'd5, 0, 8'hBE, SS + 5);
        access(0, 4'd5, 1, 8'hEF, SS + 5);
        access(0, 4'd7, 0, 8'h5A, SS + 5);
        access(0, 4'd7, 1, 8'hC3, SS + 5);
        // Even read fetches, odd read of same reg reuses the buffer
        access(1, 4'd5, 0, 8'h00, SS + 5);
        access(1, 4'd5, 1, 8'h00, SS + 5);
        // Odd read of a different register fetches fresh data
        access(1, 4'd7, 1, 8'h00, SS + 5);
        // Write between even and odd read forces a refetch
        access(1, 4'd5, 0, 8'h00, SS + 5);
        access(0, 4'd5, 0, 8'h11, SS + 5);
        access(0, 4'd5, 1, 8'h22, SS + 5);
        access(1, 4'd5, 1, 8'h00, SS + 5);
        // Odd write alone reuses the persistent high latch
        access(0, 4'd9, 1, 8'h77, SS + 5);

        // cs_n held low across reset: no access may start
        @(negedge clk);
        bus_rd_nwr_i = 1'b1; bus_reg_num_i = 4'd3; bus_bytesel_i = 1'b0;
        bus_cs_n_i = 1'b0; reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (reg_wr_o || reg_rd_o || bus_data_oe_o) strobes++;
        end
        check_val("held_cs_no_strobe", strobes, 0);
        @(negedge clk) bus_cs_n_i = 1'b1;
        repeat (4) @(posedge clk);
        access(1, 4'd3, 0, 8'h00, SS + 5);
        access(0, 4'd10, 1, 8'h99, SS + 5);

        // Early cs_n release during a fetched read, then a normal follow-up
        access(1, 4'd7, 0, 8'h00, 3);
        access(1, 4'd7, 1, 8'h00, SS + 5);

        check_val("wr_queue_empty", q_wr.size(), 0);
        check_val("rd_queue_empty", q_rd.size(), 0);
        check_val("byte_queue_empty", q_byte.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xbus_responder.md
# xbus_responder

Responder for the 8-bit register bus (cs_n / rd_nwr / reg_num / bytesel / data) that the CPU drives through its memory-mapped strobe registers. It synchronizes the asynchronous strobes into the local clock domain and assembles even/odd byte accesses into 16-bit register writes and reads toward a 16-entry register block. It drives the returned read byte back onto the bus. The block sits between the bus pins and the register file of any bus-attached peripheral.

## Interface
- SYNC_STAGES, 2, synchronizer depth for bus_cs_n_i and bus_rd_nwr_i; legal values are ≥2.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- bus_cs_n_i  in  1  async chip select, active low; its falling edge starts an access.
- bus_rd_nwr_i  in  1  async; 1 = read, 0 = write.
- bus_reg_num_i  in  4  register number; stable from before cs_n falls until cs_n rises.
- bus_bytesel_i  in  1  0 = even (high) byte, 1 = odd (low) byte.
- bus_data_i  in  8  write byte.
- bus_data_o  out  8  read byte.
- bus_data_oe_o  out  1  read-data drive enable.
- reg_wr_o  out  1  one-cycle write strobe.
- reg_wr_num_o  out  4  write register number.
- reg_wr_data_o  out  16  write data.
- reg_rd_o  out  1  one-cycle read request.
- reg_rd_num_o  out  4  read register number.
- reg_rd_data_i  in  16  read data, valid exactly 1 cycle after reg_rd_o.

## Operation
- bus_cs_n_i and bus_rd_nwr_i each pass through SYNC_STAGES flops. Call the synchronized values cs_s and rw_s.
- Arm flag: cleared by reset, set whenever cs_s = 1. A falling edge of cs_s (previous = 1, current = 0) while armed is the start event, S.
- At S: latch reg_num, bytesel and data_i into rnum, bsel and wbyte. Latch rw_s into rw.
- FSM states: IDLE, WR, RD_REQ, RD_CAP, DRIVE, WAIT_REL.
- IDLE: go to WR on S with rw = 0. Go to RD_REQ on S with rw = 1 when a fresh fetch is needed. Otherwise go to DRIVE.
- WR:
  - Even byte: hi_latch <= wbyte.
  - Odd byte: reg_wr_o = 1, reg_wr_num_o = rnum, reg_wr_data_o = {hi_latch, wbyte}.
  - Next state is WAIT_REL.
- RD_REQ: reg_rd_o = 1, reg_rd_num_o = rnum. Next state is RD_CAP.
- RD_CAP: rd_buf <= reg_rd_data_i and buf_num <= rnum. Next state is DRIVE.
- Fresh fetch rule:
  - An even-byte read always fetches.
  - An odd-byte read fetches only if rnum ≠ buf_num or no valid buffer exists.
  - An odd-byte read that does not fetch reuses rd_buf, so an even-then-odd read pair returns a coherent 16-bit value.
- DRIVE: bus_data_oe_o = 1. bus_data_o = bsel ? rd_buf[7:0] : rd_buf[15:8]. When cs_s = 1, go to IDLE and deassert oe in that same transition.
- WAIT_REL: go to IDLE when cs_s = 1.
- Buffer valid flag: cleared by reset, set in RD_CAP.
- Any register write to buf_num clears the valid flag, so a later odd read refetches.
- hi_latch persists across accesses. An odd write with no preceding even write uses the current hi_latch value (0 after reset).

## Timing
- Reset values: all outputs 0; hi_latch, rd_buf and buf_num 0; valid 0; armed 0; FSM IDLE; sync flops 1.
- Reset mid-access: all state returns to its reset value and pending strobes are dropped. If cs_n is held low through reset, no access occurs until cs_n goes high and then falls again.
- Cycle C is the cycle in which S is detected, SYNC_STAGES+1 edges after cs_n falls.
- Write: reg_wr_o is high for exactly cycle C+1.
- Fetched read: reg_rd_o at C+1, capture at C+2, bus_data_oe_o from C+3.
- Buffered odd read: bus_data_oe_o from C+1.
- oe falls on the cycle after cs_s is sampled high.
- Initiator minimum cs_n low time: SYNC_STAGES+4 clk.
- cs_n released early:
  - A write still completes.
  - A read still completes RD_REQ and RD_CAP, but DRIVE exits immediately and oe pulses for at most 1 cycle.
- cs_n glitches shorter than SYNC_STAGES cycles are not guaranteed to be filtered; the initiator must not produce them.

## Test plan
- Write 0x12 to reg 3 with bytesel 0, then 0x34 with bytesel 1 -> one reg_wr_o pulse carrying num 3, data 0x1234, at C+1 of the second access; no pulse on the first.
- Read reg 5 with downstream returning 0xBEEF: bytesel 0 -> reg_rd_o at C+1, bus_data_o = 0xBE with oe from C+3. Then bytesel 1 on reg 5 -> no reg_rd_o, bus_data_o = 0xEF.
- Odd-byte read of reg 7 after an even read of reg 5 -> new reg_rd_o with num 7; returns the low byte of the fresh data.
- Write to reg 5 between the even and odd reads of reg 5 -> the odd read refetches (reg_rd_o asserted).
- Hold cs_n low while reset_n is low for 3 cycles, then release -> no strobes. cs_n high then low -> a normal access.
- Raise cs_n 1 cycle after C during a read -> reg_rd_o still pulses once, oe is high for ≤1 cycle, FSM returns to IDLE, and the next access works.
